// File: rtl/fp_special_pipe.sv
// fp_special_pipe: two-stage IEEE-754 special-case resolver for add, sub and
// mul with a valid/ready handshake. Stage 1 captures operands, effective signs
// and operand classes; stage 2 holds the resolved result for the normal-path
// bypass mux downstream.
// Optional: define FP_SPECIAL_STATS_EN to add saturating stat_special /
// stat_invalid counters of output handshakes.
module fp_special_pipe #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   input  logic [1:0]             in_op,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_result,
   output logic                   out_special,
   output logic                   out_invalid,
   output logic [TAG_W-1:0]       out_tag
`ifdef FP_SPECIAL_STATS_EN
   ,
   output logic [CNT_W-1:0]       stat_special,
   output logic [CNT_W-1:0]       stat_invalid
`endif
);

   localparam int unsigned W = 1 + EXP_W + MAN_W;

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      CLS_ZERO,
      CLS_SUB,
      CLS_INF,
      CLS_NAN,
      CLS_NORM
   } fp_class_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   // Elaboration-time sanity check of the field widths
   if (EXP_W < 2 || MAN_W < 2 || TAG_W < 1 || CNT_W < 1) begin : g_param_check
      $error("fp_special_pipe: EXP_W and MAN_W must be >= 2, TAG_W and CNT_W >= 1");
   end

   function automatic fp_class_e classify(input logic [W-1:0] x);
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
      e = x[W-2 -: EXP_W];
      m = x[MAN_W-1:0];
      if (e == '0) begin
         classify = (m == '0) ? CLS_ZERO : CLS_SUB;
      end else if (e == '1) begin
         classify = (m == '0) ? CLS_INF : CLS_NAN;
      end else begin
         classify = CLS_NORM;
      end
   endfunction

   function automatic logic [W-1:0] quiet(input logic [W-1:0] x);
      quiet = x;
      quiet[MAN_W-1] = 1'b1;
   endfunction

   function automatic logic [W-1:0] inf_val(input logic s);
      inf_val = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   endfunction

   function automatic logic [W-1:0] zero_val(input logic s);
      zero_val = {s, {(W-1){1'b0}}};
   endfunction

   // ---------------- stage 1 state ----------------
   logic             s1_valid_q, s1_valid_d;
   logic [W-1:0]     s1_a_q, s1_a_d;
   logic [W-1:0]     s1_b_q, s1_b_d;
   fp_class_e        s1_ca_q, s1_ca_d;
   fp_class_e        s1_cb_q, s1_cb_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

   // ---------------- stage 2 state ----------------
   logic             s2_valid_q, s2_valid_d;
   logic [W-1:0]     s2_result_q, s2_result_d;
   logic             s2_special_q, s2_special_d;
   logic             s2_invalid_q, s2_invalid_d;
   logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

   logic             s2_load;
   logic             s1_load;
   logic [W-1:0]     b_eff;
   logic [W-1:0]     res_result;
   logic             res_special;
   logic             res_invalid;
   logic             sa, sb;

   // Handshake: each stage refills when empty or when its content moves on
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      s1_load  = !s1_valid_q || s2_load;
      in_ready = s1_load;
   end

   // Stage 1 next state: capture operands with B's sign flipped for sub
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_ca_d    = s1_ca_q;
      s1_cb_d    = s1_cb_q;
      s1_op_d    = s1_op_q;
      s1_tag_d   = s1_tag_q;
      b_eff      = in_b;
      if (in_op == OP_SUB) begin
         b_eff[W-1] = ~in_b[W-1];
      end
      if (s1_load) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d   = in_a;
            s1_b_d   = b_eff;
            s1_ca_d  = classify(in_a);
            s1_cb_d  = classify(b_eff);
            s1_op_d  = in_op;
            s1_tag_d = in_tag;
         end
      end
   end

   // Stage 1 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_ca_q    <= CLS_ZERO;
         s1_cb_q    <= CLS_ZERO;
         s1_op_q    <= '0;
         s1_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_ca_q    <= s1_ca_d;
         s1_cb_q    <= s1_cb_d;
         s1_op_q    <= s1_op_d;
         s1_tag_q   <= s1_tag_d;
      end
   end

   // Special-case resolution of the stage 1 operands, first matching rule wins
   always_comb begin
      res_result  = '0;
      res_special = 1'b0;
      res_invalid = 1'b0;
      sa          = s1_a_q[W-1];
      sb          = s1_b_q[W-1];
      if (s1_valid_q) begin
         case (s1_op_q)
            OP_ADD, OP_SUB: begin
               if (s1_ca_q == CLS_NAN) begin
                  res_result  = quiet(s1_a_q);
                  res_special = 1'b1;
               end else if (s1_cb_q == CLS_NAN) begin
                  res_result  = quiet(s1_b_q);
                  res_special = 1'b1;
               end else if (s1_ca_q == CLS_INF && s1_cb_q == CLS_INF) begin
                  res_special = 1'b1;
                  if (sa != sb) begin
                     res_result  = QNAN;
                     res_invalid = 1'b1;
                  end else begin
                     res_result = s1_a_q;
                  end
               end else if (s1_ca_q == CLS_INF) begin
                  res_result  = s1_a_q;
                  res_special = 1'b1;
               end else if (s1_cb_q == CLS_INF) begin
                  res_result  = s1_b_q;
                  res_special = 1'b1;
               end else if (s1_ca_q == CLS_ZERO && s1_cb_q == CLS_ZERO) begin
                  res_result  = zero_val(sa & sb);
                  res_special = 1'b1;
               end else if (s1_ca_q == CLS_ZERO) begin
                  res_result  = s1_b_q;
                  res_special = 1'b1;
               end else if (s1_cb_q == CLS_ZERO) begin
                  res_result  = s1_a_q;
                  res_special = 1'b1;
               end
            end
            OP_MUL: begin
               if (s1_ca_q == CLS_NAN) begin
                  res_result  = quiet(s1_a_q);
                  res_special = 1'b1;
               end else if (s1_cb_q == CLS_NAN) begin
                  res_result  = quiet(s1_b_q);
                  res_special = 1'b1;
               end else if ((s1_ca_q == CLS_INF && s1_cb_q == CLS_ZERO) ||
                            (s1_ca_q == CLS_ZERO && s1_cb_q == CLS_INF)) begin
                  res_result  = QNAN;
                  res_special = 1'b1;
                  res_invalid = 1'b1;
               end else if (s1_ca_q == CLS_INF || s1_cb_q == CLS_INF) begin
                  res_result  = inf_val(sa ^ sb);
                  res_special = 1'b1;
               end else if (s1_ca_q == CLS_ZERO || s1_cb_q == CLS_ZERO) begin
                  res_result  = zero_val(sa ^ sb);
                  res_special = 1'b1;
               end
            end
            default: begin
               res_result  = QNAN;
               res_special = 1'b1;
               res_invalid = 1'b1;
            end
         endcase
      end
   end

   // Stage 2 next state: advance when empty or consumed, otherwise hold
   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_result_d  = s2_result_q;
      s2_special_d = s2_special_q;
      s2_invalid_d = s2_invalid_q;
      s2_tag_d     = s2_tag_q;
      if (s2_load) begin
         s2_valid_d   = s1_valid_q;
         s2_result_d  = res_result;
         s2_special_d = res_special;
         s2_invalid_d = res_invalid;
         s2_tag_d     = s1_valid_q ? s1_tag_q : '0;
      end
   end

   // Stage 2 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_special_q <= 1'b0;
         s2_invalid_q <= 1'b0;
         s2_tag_q     <= '0;
      end else begin
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_special_q <= s2_special_d;
         s2_invalid_q <= s2_invalid_d;
         s2_tag_q     <= s2_tag_d;
      end
   end

   // Output drive straight from stage 2
   always_comb begin
      out_valid   = s2_valid_q;
      out_result  = s2_result_q;
      out_special = s2_special_q;
      out_invalid = s2_invalid_q;
      out_tag     = s2_tag_q;
   end

`ifdef FP_SPECIAL_STATS_EN
   logic [CNT_W-1:0] stat_special_q, stat_special_d;
   logic [CNT_W-1:0] stat_invalid_q, stat_invalid_d;
   logic             out_fire;

   // Saturating counters of output handshakes carrying special / invalid
   always_comb begin
      out_fire       = s2_valid_q && out_ready;
      stat_special_d = stat_special_q;
      stat_invalid_d = stat_invalid_q;
      if (out_fire && s2_special_q && stat_special_q != '1) begin
         stat_special_d = stat_special_q + 1'b1;
      end
      if (out_fire && s2_invalid_q && stat_invalid_q != '1) begin
         stat_invalid_d = stat_invalid_q + 1'b1;
      end
   end

   // Statistics register
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_special_q <= '0;
         stat_invalid_q <= '0;
      end else begin
         stat_special_q <= stat_special_d;
         stat_invalid_q <= stat_invalid_d;
      end
   end

   // Statistics output drive
   always_comb begin
      stat_special = stat_special_q;
      stat_invalid = stat_invalid_q;
   end
`endif

endmodule
